load_store_unit: RTL and testbench
==================================

# load_store_unit

Load/store unit that initiates every data-memory access for the RISC-V core's MEM stage. It takes the ALU-computed address, store data and the funct3 access type, and drives a request/grant/response handshake to the data memory. It also generates byte enables and lane-replicated store data, and sign/zero-extends load data. The pipeline is stalled until each access completes.

## Interface
Parameters:
- WIDTH, 32, data and address width (fixed at 32 for RV32I; other values unsupported)

Ports:
- clk  input  1  core clock, all state updates on rising edge
- rst_n  input  1  asynchronous, active-low reset
- mem_read  input  1  MEM-stage load instruction present
- mem_write  input  1  MEM-stage store instruction present (wins over mem_read if both set)
- funct3  input  3  access type: 000 LB/SB, 001 LH/SH, 010 LW/SW, 100 LBU, 101 LHU; other codes treated as word
- aluresult  input  WIDTH  byte address
- wdata  input  WIDTH  store data (rs2 value, data in low bits)
- stall  output  1  freeze pipeline while an access is in flight
- rdata  output  WIDTH  extended load result, valid when rdata_valid
- rdata_valid  output  1  one-cycle pulse in the completion cycle of a load
- misaligned  output  1  one-cycle pulse: access rejected, no memory traffic
- mem_req  output  1  request valid to data memory
- mem_we  output  1  1 = write, 0 = read
- mem_addr  output  WIDTH  word-aligned address ({aluresult[31:2],2'b00})
- mem_be  output  4  byte enables
- mem_wdata  output  WIDTH  lane-replicated store data
- mem_gnt  input  1  memory accepts request this cycle
- mem_rvalid  input  1  read data valid
- mem_rdata  input  WIDTH  full word read data

## Operation
- States: IDLE, REQ, WAIT_RSP, DONE.
- IDLE, access present (mem_read|mem_write):
  - If misaligned (word with aluresult[1:0]≠0; half with aluresult[0]=1): pulse misaligned and stay in IDLE. stall=0.
  - Otherwise, register address, be, wdata, we, funct3; go to REQ. stall=1 combinationally this cycle.
- REQ: mem_req=1 with stable registered fields until mem_gnt. On gnt: store → DONE, load → WAIT_RSP.
- WAIT_RSP: wait for mem_rvalid, capture the extracted and extended result into rdata, go to DONE.
- DONE: stall=0, rdata_valid=1 for loads, unconditionally → IDLE. The pipeline advances at the end of DONE; the still-asserted mem_read/mem_write does not relaunch.
- Byte enables: byte 4'b0001<<aluresult[1:0]; half 4'b0011<<aluresult[1:0]; word 4'b1111.
- Store data: byte {4{wdata[7:0]}}; half {2{wdata[15:0]}}; word wdata.
- Load extract: select the byte/half at the offset. LB/LH sign-extend from bit 7/15; LBU/LHU zero-extend.
- mem_rvalid outside WAIT_RSP is ignored. The responder asserts rvalid no earlier than the cycle after gnt.

## Timing
- Reset values: state IDLE, stall 0 (combinational from state), mem_req 0, mem_we 0, mem_addr 0, mem_be 0, mem_wdata 0, rdata 0, rdata_valid 0, misaligned 0.
- Store with gnt in the first REQ cycle: stall high for 2 cycles (accept, REQ), low in DONE.
- Load with gnt immediate and rvalid the next cycle: stall high for 3 cycles, rdata valid in cycle 4 (DONE).
- Each cycle of gnt or rvalid delay adds one stall cycle.
- rdata holds its value after DONE until the next load completes.
- Reset asserted mid-access: immediate return to IDLE, mem_req drops asynchronously, the transaction is abandoned, and late responses are ignored.

## Structure
- lsu_pkg: state enum, funct3 constants (F3_B, F3_H, F3_W, F3_BU, F3_HU), size enum.
- Sub-module lsu_align: purely combinational be/wdata generation, load extraction/extension, and misaligned detection. The FSM and registers stay in load_store_unit.

## Test plan
- SB 0xA5 at 0x1002 (wdata 0x123456A5), gnt immediate → mem_be 0100, mem_wdata 0xA5A5A5A5, mem_addr 0x1000, stall high exactly 2 cycles.
- LB at 0x1003, mem_rdata 0x80FF7F01, rvalid one cycle after gnt → rdata 0xFFFFFF80, rdata_valid one pulse, stall high 3 cycles; LBU same → 0x00000080.
- LH at 0x1002 with mem_rdata 0x8001xxxx → 0xFFFF8001; LW at 0x1001 → misaligned pulse, mem_req never asserts, stall 0.
- SW with gnt delayed 3 cycles → mem_addr/be/wdata stable throughout REQ, stall high 5 cycles.
- rst_n low while in WAIT_RSP, then rvalid arrives → all outputs at reset values, no rdata_valid; the next LW completes normally.

Source files
------------

// File: rtl/lsu_pkg.sv
// Shared types and constants for the load/store unit.
// Provides FSM states, funct3 access codes and access-size decoding.
package lsu_pkg;

    typedef enum logic [1:0] {
        IDLE,
        REQ,
        WAIT_RSP,
        DONE
    } state_e;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    typedef enum logic [1:0] {
        SZ_B,
        SZ_H,
        SZ_W
    } size_e;

    // Any code that is not an explicit byte/half access is a word access.
    function automatic size_e f3_size(input logic [2:0] f3);
        size_e sz;
        case (f3)
            F3_B, F3_BU: sz = SZ_B;
            F3_H, F3_HU: sz = SZ_H;
            default:     sz = SZ_W;
        endcase
        return sz;
    endfunction

endpackage

// File: rtl/lsu_align.sv
// Combinational lane logic: byte enables, store replication,
// misalignment detection and load extraction/extension.
// Ports: req_f3_i/req_off_i/wdata_i (request side) -> be_o, wdata_o,
//        misaligned_o; rsp_f3_i/rsp_off_i/rdata_i (response side) -> rdata_o.
module lsu_align
    import lsu_pkg::*;
(
    input  logic [2:0]  req_f3_i,
    input  logic [1:0]  req_off_i,
    input  logic [31:0] wdata_i,
    input  logic [2:0]  rsp_f3_i,
    input  logic [1:0]  rsp_off_i,
    input  logic [31:0] rdata_i,
    output logic [3:0]  be_o,
    output logic [31:0] wdata_o,
    output logic        misaligned_o,
    output logic [31:0] rdata_o
);

    size_e       qsz;
    size_e       rsz;
    logic        sext;
    logic [7:0]  bsel;
    logic [15:0] hsel;

    assign qsz  = f3_size(req_f3_i);
    assign rsz  = f3_size(rsp_f3_i);
    // funct3[2] marks the unsigned load variants.
    assign sext = ~rsp_f3_i[2];
    assign bsel = rdata_i[{rsp_off_i, 3'b000} +: 8];
    assign hsel = rdata_i[{rsp_off_i[1], 4'b0000} +: 16];

    always_comb begin
        be_o         = 4'b1111;
        wdata_o      = wdata_i;
        misaligned_o = |req_off_i;
        case (qsz)
            SZ_B: begin
                be_o         = 4'b0001 << req_off_i;
                wdata_o      = {4{wdata_i[7:0]}};
                misaligned_o = 1'b0;
            end
            SZ_H: begin
                be_o         = 4'b0011 << req_off_i;
                wdata_o      = {2{wdata_i[15:0]}};
                misaligned_o = req_off_i[0];
            end
            default: begin
                be_o         = 4'b1111;
                wdata_o      = wdata_i;
                misaligned_o = |req_off_i;
            end
        endcase
    end

    always_comb begin
        rdata_o = rdata_i;
        case (rsz)
            SZ_B:    rdata_o = {{24{sext & bsel[7]}}, bsel};
            SZ_H:    rdata_o = {{16{sext & hsel[15]}}, hsel};
            default: rdata_o = rdata_i;
        endcase
    end

endmodule

// File: rtl/load_store_unit.sv
// MEM-stage load/store unit: req/gnt/rvalid data-memory handshake,
// pipeline stall, byte lanes and load extension.
// Ports: mem_read/mem_write/funct3/aluresult/wdata from the pipeline;
//        stall/rdata/rdata_valid/misaligned back to it; mem_* to memory.
module load_store_unit
    import lsu_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             mem_read,
    input  logic             mem_write,
    input  logic [2:0]       funct3,
    input  logic [WIDTH-1:0] aluresult,
    input  logic [WIDTH-1:0] wdata,
    output logic             stall,
    output logic [WIDTH-1:0] rdata,
    output logic             rdata_valid,
    output logic             misaligned,
    output logic             mem_req,
    output logic             mem_we,
    output logic [WIDTH-1:0] mem_addr,
    output logic [3:0]       mem_be,
    output logic [WIDTH-1:0] mem_wdata,
    input  logic             mem_gnt,
    input  logic             mem_rvalid,
    input  logic [WIDTH-1:0] mem_rdata
);

    state_e           state_q;
    state_e           state_d;
    logic [WIDTH-1:0] addr_q;
    logic [1:0]       off_q;
    logic [3:0]       be_q;
    logic [WIDTH-1:0] wdata_q;
    logic             we_q;
    logic [2:0]       f3_q;
    logic [WIDTH-1:0] rdata_q;

    logic             launch;
    logic             capture;
    logic             mis;
    logic [3:0]       be_n;
    logic [WIDTH-1:0] wdata_n;
    logic [WIDTH-1:0] rext;

    lsu_align u_align (
        .req_f3_i     (funct3),
        .req_off_i    (aluresult[1:0]),
        .wdata_i      (wdata),
        .rsp_f3_i     (f3_q),
        .rsp_off_i    (off_q),
        .rdata_i      (mem_rdata),
        .be_o         (be_n),
        .wdata_o      (wdata_n),
        .misaligned_o (mis),
        .rdata_o      (rext)
    );

    always_comb begin
        state_d    = state_q;
        stall      = 1'b0;
        misaligned = 1'b0;
        launch     = 1'b0;
        capture    = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (mem_read | mem_write) begin
                    if (mis) begin
                        misaligned = 1'b1;
                    end else begin
                        launch  = 1'b1;
                        stall   = 1'b1;
                        state_d = REQ;
                    end
                end
            end
            REQ: begin
                stall = 1'b1;
                if (mem_gnt) begin
                    state_d = we_q ? DONE : WAIT_RSP;
                end
            end
            WAIT_RSP: begin
                stall = 1'b1;
                if (mem_rvalid) begin
                    capture = 1'b1;
                    state_d = DONE;
                end
            end
            // The pipeline advances out of DONE, so a still-asserted
            // request seen here belongs to the finished instruction.
            DONE: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            addr_q  <= '0;
            off_q   <= '0;
            be_q    <= '0;
            wdata_q <= '0;
            we_q    <= 1'b0;
            f3_q    <= '0;
            rdata_q <= '0;
        end else begin
            state_q <= state_d;
            if (launch) begin
                addr_q  <= {aluresult[WIDTH-1:2], 2'b00};
                off_q   <= aluresult[1:0];
                be_q    <= be_n;
                wdata_q <= wdata_n;
                we_q    <= mem_write;
                f3_q    <= funct3;
            end
            if (capture) begin
                rdata_q <= rext;
            end
        end
    end

    assign mem_req     = (state_q == REQ);
    assign mem_we      = we_q;
    assign mem_addr    = addr_q;
    assign mem_be      = be_q;
    assign mem_wdata   = wdata_q;
    assign rdata       = rdata_q;
    assign rdata_valid = (state_q == DONE) & ~we_q;

endmodule

// File: tb/tb_load_store_unit.sv
// Scoreboard bench for load_store_unit: driver pushes expectations,
// monitor compares requests, load results and misaligned pulses.
module tb_load_store_unit;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        mem_read = 1'b0;
    logic        mem_write = 1'b0;
    logic [2:0]  funct3 = '0;
    logic [31:0] aluresult = '0;
    logic [31:0] wdata = '0;
    logic        stall;
    logic [31:0] rdata;
    logic        rdata_valid;
    logic        misaligned;
    logic        mem_req;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [3:0]  mem_be;
    logic [31:0] mem_wdata;
    logic        mem_gnt = 1'b0;
    logic        mem_rvalid = 1'b0;
    logic [31:0] mem_rdata = '0;

    always #5 clk = ~clk;

    load_store_unit #(.WIDTH(32)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .mem_read    (mem_read),
        .mem_write   (mem_write),
        .funct3      (funct3),
        .aluresult   (aluresult),
        .wdata       (wdata),
        .stall       (stall),
        .rdata       (rdata),
        .rdata_valid (rdata_valid),
        .misaligned  (misaligned),
        .mem_req     (mem_req),
        .mem_we      (mem_we),
        .mem_addr    (mem_addr),
        .mem_be      (mem_be),
        .mem_wdata   (mem_wdata),
        .mem_gnt     (mem_gnt),
        .mem_rvalid  (mem_rvalid),
        .mem_rdata   (mem_rdata)
    );

    typedef struct {
        logic [31:0] addr;
        logic [3:0]  be;
        logic [31:0] wd;
        logic        we;
    } req_t;

    int          checks = 0;
    int          errors = 0;
    req_t        req_q[$];
    logic [31:0] rsp_q[$];
    int          mis_pend = 0;
    logic [31:0] last_rd = '0;

    int          gnt_dly = 0;
    int          rsp_dly = 1;
    logic [31:0] rsp_word = '0;
    int          gcnt = 0;
    int          rcnt = 0;
    bit          rpend = 0;

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %h expected %h", name, act, exp);
        end
    endtask

    task automatic unexpected(input string name);
        checks++;
        errors++;
        $display("FAIL %s got event expected none", name);
    endtask

    function automatic int acc_size(input logic [2:0] f3);
        if (f3 == 3'd0 || f3 == 3'd4) return 1;
        if (f3 == 3'd1 || f3 == 3'd5) return 2;
        return 4;
    endfunction

    function automatic logic [31:0] exp_load(input logic [31:0] w,
                                             input logic [2:0] f3,
                                             input int off);
        int          sz;
        logic [31:0] v;
        sz = acc_size(f3);
        v  = w >> (8 * off);
        if (sz == 1) begin
            v = v & 32'hFF;
            if (f3 == 3'd0 && v >= 32'h80) v = v + 32'hFFFFFF00;
        end else if (sz == 2) begin
            v = v & 32'hFFFF;
            if (f3 == 3'd1 && v >= 32'h8000) v = v + 32'hFFFF0000;
        end
        return v;
    endfunction

    // Memory responder: grant after gnt_dly REQ cycles, data rsp_dly
    // cycles after the grant. A pending response survives reset on purpose.
    always @(posedge clk) begin
        #1;
        mem_gnt    = 1'b0;
        mem_rvalid = 1'b0;
        mem_rdata  = $urandom;
        if (rpend) begin
            if (rcnt >= rsp_dly) begin
                mem_rvalid = 1'b1;
                mem_rdata  = rsp_word;
                rpend      = 0;
            end else begin
                rcnt++;
            end
        end
        if (mem_req) begin
            if (gcnt >= gnt_dly) begin
                mem_gnt = 1'b1;
                gcnt    = 0;
                if (!mem_we) begin
                    rpend = 1;
                    rcnt  = 1;
                end
            end else begin
                gcnt++;
            end
        end
    end

    // Monitor
    always @(negedge clk) begin
        if (rst_n) begin
            if (mem_req) begin
                if (req_q.size() == 0) begin
                    unexpected("mem_req");
                end else begin
                    chk("mem_addr", mem_addr, req_q[0].addr);
                    chk("mem_be", {28'd0, mem_be}, {28'd0, req_q[0].be});
                    chk("mem_we", {31'd0, mem_we}, {31'd0, req_q[0].we});
                    if (req_q[0].we) chk("mem_wdata", mem_wdata, req_q[0].wd);
                    if (mem_gnt) void'(req_q.pop_front());
                end
            end
            if (rdata_valid) begin
                if (rsp_q.size() == 0) unexpected("rdata_valid");
                else chk("rdata", rdata, rsp_q.pop_front());
            end
            if (misaligned) begin
                if (mis_pend == 0) begin
                    unexpected("misaligned");
                end else begin
                    checks++;
                    mis_pend--;
                end
            end
        end
    end

    task automatic access(input bit rd, input bit wr, input logic [2:0] f3,
                          input logic [31:0] a, input logic [31:0] wd,
                          input int gd, input int rdl,
                          input logic [31:0] word);
        int   sz;
        int   off;
        int   n;
        int   exp_stall;
        req_t r;
        @(posedge clk);
        #1;
        gnt_dly   = gd;
        rsp_dly   = rdl;
        rsp_word  = word;
        mem_read  = rd;
        mem_write = wr;
        funct3    = f3;
        aluresult = a;
        wdata     = wd;
        sz        = acc_size(f3);
        off       = int'(a[1:0]);
        exp_stall = 0;
        if (rd || wr) begin
            if ((off % sz) != 0) begin
                mis_pend++;
            end else begin
                r.addr = a & 32'hFFFF_FFFC;
                r.be   = 4'(((1 << sz) - 1) << off);
                r.we   = wr;
                if (sz == 1) r.wd = {4{wd[7:0]}};
                else if (sz == 2) r.wd = {2{wd[15:0]}};
                else r.wd = wd;
                req_q.push_back(r);
                if (wr) begin
                    exp_stall = 2 + gd;
                end else begin
                    exp_stall = 2 + gd + rdl;
                    last_rd   = exp_load(word, f3, off);
                    rsp_q.push_back(last_rd);
                end
            end
        end
        n = 0;
        @(negedge clk);
        while (stall && n < 60) begin
            n++;
            @(negedge clk);
        end
        chk("stall_cycles", n, exp_stall);
    endtask

    task automatic idle(input int cycles);
        for (int i = 0; i < cycles; i++) begin
            @(posedge clk);
            #1;
            mem_read  = 1'b0;
            mem_write = 1'b0;
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        #2;
        chk("rst_stall", {31'd0, stall}, 32'd0);
        chk("rst_mem_req", {31'd0, mem_req}, 32'd0);
        chk("rst_mem_we", {31'd0, mem_we}, 32'd0);
        chk("rst_mem_addr", mem_addr, 32'd0);
        chk("rst_mem_be", {28'd0, mem_be}, 32'd0);
        chk("rst_mem_wdata", mem_wdata, 32'd0);
        chk("rst_rdata", rdata, 32'd0);
        chk("rst_rdata_valid", {31'd0, rdata_valid}, 32'd0);
        chk("rst_misaligned", {31'd0, misaligned}, 32'd0);
        #20;
        rst_n = 1'b1;
        idle(2);

        access(0, 1, 3'd0, 32'h1002, 32'h1234_56A5, 0, 1, 32'h0);
        access(1, 0, 3'd0, 32'h1003, 32'h0, 0, 1, 32'h80FF_7F01);
        access(1, 0, 3'd4, 32'h1003, 32'h0, 0, 1, 32'h80FF_7F01);
        access(1, 0, 3'd1, 32'h1002, 32'h0, 0, 1, 32'h8001_5A3C);
        access(1, 0, 3'd2, 32'h1001, 32'h0, 0, 1, 32'h0);
        access(0, 1, 3'd2, 32'h2008, 32'hDEAD_BEEF, 3, 1, 32'h0);
        idle(3);
        chk("rdata_hold", rdata, last_rd);

        // Reset while waiting for the read response.
        @(posedge clk);
        #1;
        gnt_dly   = 0;
        rsp_dly   = 4;
        rsp_word  = 32'hCAFE_F00D;
        mem_read  = 1'b1;
        funct3    = 3'd2;
        aluresult = 32'h2000;
        req_q.push_back('{addr: 32'h2000, be: 4'hF, wd: 32'h0, we: 1'b0});
        @(negedge clk);
        @(negedge clk);
        @(negedge clk);
        chk("wait_stall", {31'd0, stall}, 32'd1);
        #2;
        rst_n    = 1'b0;
        mem_read = 1'b0;
        #1;
        chk("arst_stall", {31'd0, stall}, 32'd0);
        chk("arst_mem_req", {31'd0, mem_req}, 32'd0);
        chk("arst_rdata", rdata, 32'd0);
        chk("arst_mem_addr", mem_addr, 32'd0);
        chk("arst_rdata_valid", {31'd0, rdata_valid}, 32'd0);
        @(posedge clk);
        #3;
        rst_n = 1'b1;
        idle(8);
        chk("late_rsp_rdata", rdata, 32'd0);
        chk("late_rsp_stall", {31'd0, stall}, 32'd0);
        last_rd = '0;
        access(1, 0, 3'd2, 32'h3004, 32'h0, 0, 1, 32'h1357_9BDF);

        for (int i = 0; i < 80; i++) begin
            int op;
            op = int'($urandom_range(0, 2));
            access(op != 1, op != 0, 3'($urandom_range(0, 7)), $urandom,
                   $urandom, int'($urandom_range(0, 3)),
                   int'($urandom_range(1, 3)), $urandom);
            if ($urandom_range(0, 3) == 0) idle(1);
        end
        idle(4);
        chk("req_q_empty", req_q.size(), 32'd0);
        chk("rsp_q_empty", rsp_q.size(), 32'd0);
        chk("mis_pend_zero", mis_pend, 32'd0);
        chk("final_rdata", rdata, last_rd);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
